line_follow_ctrl: RTL
=====================

// Module: line_follow_ctrl
// PURPOSE
//  Clocked, parametrised line-following drive controller for the rover. Reads N active-low inductive
//  tape sensors, proximity and red-junction inputs; drives H-bridge direction/enable for two motors.
//  An FSM handles following, lost-line recovery, cone 180s and junction branch selection. Sits between
//  the sensor front end and the H-bridge pins.
// PARAMETERS
//  N_SENSE      3     tape sensor count; odd, >=3; bit N_SENSE-1 = leftmost, bit 0 = rightmost
//  DEBOUNCE     4     consecutive stable cycles before a synced sensor/proxim/red value is accepted (>=1)
//  TURN_CYCLES  1000  cycles a cone 180 or junction turn is forced before line tracking resumes
//  LOST_CYCLES  5000  cycles with no tape before the FSM gives up and stops
//  PWM_W        8     duty/PWM counter width (used only with ROVER_PWM_EN)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  run        in   1        1 = drive enabled; 0 = go to IDLE next cycle
//  induct     in   N_SENSE  tape sensors, active-low (0 = on tape), asynchronous
//  proxim     in   1        cone detected, active-high, asynchronous
//  red        in   1        red junction marker under rover, active-high, asynchronous
//  duty       in   PWM_W    motor duty, 0..2^PWM_W-1 (ignored without ROVER_PWM_EN)
//  motor_in   out  4        direction: FWD 0110, LEFT 1010, RIGHT 0101, OFF 0000
//  motor_en   out  2        motor enables, 11 = both on
//  state_o    out  3        current FSM state code (debug)
//  cone_seen  out  1        cone encountered since last red falling edge
// BEHAVIOUR
//  - All outputs registered. Reset: motor_in=0000, motor_en=00, state_o=IDLE(0), cone_seen=0,
//    branch_sel=0, last_dir=FWD, all counters 0. Reset mid-turn aborts immediately.
//  - Inputs: 2-flop sync, then per-signal debounce counter; filtered value changes only after DEBOUNCE
//    stable cycles. Latency raw induct edge -> motor_in change = DEBOUNCE+3 cycles.
//  - Classify filtered tape (t = ~induct): L = |t[N-1:N/2+1], C = t[N/2], R = |t[N/2-1:0].
//    ALL = &t -> JUNC; NONE = ~|t -> LOST; L&~R -> LEFT; R&~L -> RIGHT; otherwise FWD.
//  - States: IDLE(0) FOLLOW(1) LOST(2) AVOID(3) JUNC(4) STOP(5). Every state -> IDLE when run=0.
//    IDLE: OFF, en=00; run=1 -> FOLLOW.
//    FOLLOW: motor_in = class dir, en=11, last_dir <= class dir (LEFT/RIGHT/FWD). Priority each cycle:
//      proxim -> AVOID; ALL -> JUNC; NONE -> LOST; else stay.
//    AVOID: set cone_seen; drive LEFT for exactly TURN_CYCLES, then FOLLOW (ALL/NONE re-evaluated there).
//      proxim held at exit re-enters AVOID next cycle; proxim inside AVOID does not restart the count.
//    JUNC: dir = (branch_sel ^ cone_seen) ? LEFT : RIGHT, held TURN_CYCLES, then FOLLOW.
//      proxim in JUNC -> AVOID (proxim wins).
//    LOST: drive last_dir (FWD if last_dir=FWD), count; any tape -> FOLLOW, count cleared;
//      count reaches LOST_CYCLES -> STOP.
//    STOP: OFF, en=00; any tape -> FOLLOW.
//  - red rising edge (filtered): branch_sel toggles. red falling edge: cone_seen clears. Same-cycle
//    proxim and red falling: cone_seen ends 1 (set wins).
//  - Counters sized $clog2(max(TURN_CYCLES,LOST_CYCLES)+1); saturate, never wrap.
// CONFIGURATION
//  ROVER_PWM_EN defined: free-running PWM_W-bit counter; in driving states motor_en = {2{cnt < duty}}
//    (duty=0 -> always 00, duty=max -> 11 except 1 of 2^PWM_W cycles); motor_in unchanged.
//  Undefined: motor_en = 11 in all driving states; duty ignored; no PWM counter synthesised.
// TESTING (N_SENSE=3, DEBOUNCE=2, TURN_CYCLES=8, LOST_CYCLES=16, PWM off unless noted)
//  1 reset=1 two cycles, run=1, induct=101 -> after reset: 0000/00, then FOLLOW, motor_in=0110 en=11.
//  2 induct 101->011 (left on tape) -> motor_in=1010 exactly 5 cycles after edge; 011->110 -> 0101.
//  3 induct=111 after RIGHT -> LOST, motor_in=0101 for 16 cycles, then STOP 0000/00; induct=101 -> 0110.
//  4 proxim pulse 10 cycles in FOLLOW -> AVOID, 1010 for 8 cycles, cone_seen=1; red rise+fall -> cone_seen=0.
//  5 induct=000, branch_sel=0, cone_seen=0 -> 0101 for 8 cycles; red pulse then 000 -> 1010;
//    with cone_seen=1 -> 0101. proxim same cycle as 000 -> AVOID.
//  6 ROVER_PWM_EN, PWM_W=4, duty=4 -> motor_en=11 for 4 of every 16 cycles; run=0 mid-JUNC -> IDLE next cycle.

Source files
------------

// File: rtl/line_follow_ctrl.sv
// Line-following rover drive controller: synchronised and debounced sensors, follow/recovery FSM, H-bridge outputs.
// Optional feature macro: ROVER_PWM_EN (PWM gating of motor_en by duty).
module line_follow_ctrl #(
   parameter int unsigned N_SENSE     = 3,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned TURN_CYCLES = 1000,
   parameter int unsigned LOST_CYCLES = 5000,
   parameter int unsigned PWM_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [N_SENSE-1:0] induct,
   input  logic               proxim,
   input  logic               red,
   input  logic [PWM_W-1:0]   duty,
   output logic [3:0]         motor_in,
   output logic [1:0]         motor_en,
   output logic [2:0]         state_o,
   output logic               cone_seen
);

   localparam int unsigned NS   = N_SENSE + 2;
   localparam int unsigned MID  = N_SENSE / 2;
   localparam int unsigned DBW  = $clog2(DEBOUNCE + 1);
   localparam int unsigned CMAX = (TURN_CYCLES > LOST_CYCLES) ? TURN_CYCLES : LOST_CYCLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   localparam logic [3:0]     DIR_OFF   = 4'b0000;
   localparam logic [3:0]     DIR_FWD   = 4'b0110;
   localparam logic [3:0]     DIR_LEFT  = 4'b1010;
   localparam logic [3:0]     DIR_RIGHT = 4'b0101;
   // Sensor vector is {red, proxim, induct}; induct idles high (no tape) out of reset.
   localparam logic [NS-1:0]  FILT_RST  = {2'b00, {N_SENSE{1'b1}}};
   localparam logic [DBW-1:0] DB_END    = DBW'(DEBOUNCE - 1);
   localparam logic [CW-1:0]  TURN_END  = CW'(TURN_CYCLES - 1);
   localparam logic [CW-1:0]  LOST_END  = CW'(LOST_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_SAT   = CW'(CMAX);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FOLLOW = 3'd1,
      S_LOST   = 3'd2,
      S_AVOID  = 3'd3,
      S_JUNC   = 3'd4,
      S_STOP   = 3'd5
   } state_e;

   logic [NS-1:0]  sync1_q, sync2_q, filt_q, filt_d;
   logic [DBW-1:0] db_cnt_q [NS];
   logic [DBW-1:0] db_cnt_d [NS];

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [3:0]     motor_q, motor_d, last_dir_q, last_dir_d, class_dir, junc_dir;
   logic [1:0]     en_q, en_d;
   logic           branch_q, branch_d, cone_q, cone_d, red_prev_q;
   logic           drive, pwm_on;

   logic [N_SENSE-1:0] tape;
   logic               tl, tr, t_all, t_none, prox_f, red_f;

   always_comb begin
      filt_d = filt_q;
      for (int unsigned i = 0; i < NS; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (db_cnt_q[i] == DB_END) filt_d[i] = sync2_q[i];
            else                       db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= FILT_RST;
         sync2_q <= FILT_RST;
         filt_q  <= FILT_RST;
         for (int unsigned i = 0; i < NS; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= {red, proxim, induct};
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         for (int unsigned i = 0; i < NS; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign tape   = ~filt_q[N_SENSE-1:0];
   assign tl     = |tape[N_SENSE-1:MID+1];
   assign tr     = |tape[MID-1:0];
   assign t_all  = &tape;
   assign t_none = ~|tape;
   assign prox_f = filt_q[N_SENSE];
   assign red_f  = filt_q[N_SENSE+1];

   assign class_dir = (tl & ~tr) ? DIR_LEFT : (tr & ~tl) ? DIR_RIGHT : DIR_FWD;
   assign junc_dir  = (branch_q ^ cone_q) ? DIR_LEFT : DIR_RIGHT;
   assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

`ifdef ROVER_PWM_EN
   logic [PWM_W-1:0] pwm_q;
   always_ff @(posedge clk) begin
      if (reset) pwm_q <= '0;
      else       pwm_q <= pwm_q + 1'b1;
   end
   assign pwm_on = (pwm_q < duty);
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign pwm_on      = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      motor_d    = DIR_OFF;
      drive      = 1'b0;
      last_dir_d = last_dir_q;
      branch_d   = branch_q;
      cone_d     = cone_q;

      case (state_q)
         S_IDLE:   if (run) state_d = S_FOLLOW;
         S_FOLLOW: begin
            if (prox_f)      state_d = S_AVOID;
            else if (t_all)  state_d = S_JUNC;
            else if (t_none) state_d = S_LOST;
         end
         S_AVOID:  if (cnt_q == TURN_END) state_d = S_FOLLOW;
         S_JUNC: begin
            if (prox_f)                  state_d = S_AVOID;
            else if (cnt_q == TURN_END)  state_d = S_FOLLOW;
         end
         S_LOST: begin
            if (!t_none)                 state_d = S_FOLLOW;
            else if (cnt_q == LOST_END)  state_d = S_STOP;
         end
         S_STOP:   if (!t_none) state_d = S_FOLLOW;
         default:  state_d = S_IDLE;
      endcase
      if (!run) state_d = S_IDLE;

      // The shared timer runs only while a timed state is held; any transition restarts it.
      if (state_d == state_q && (state_q == S_AVOID || state_q == S_JUNC || state_q == S_LOST))
         cnt_d = cnt_inc;

      // Outputs are registered alongside the state they belong to.
      case (state_d)
         S_FOLLOW: begin motor_d = class_dir;  drive = 1'b1; end
         S_AVOID:  begin motor_d = DIR_LEFT;   drive = 1'b1; end
         S_JUNC:   begin motor_d = junc_dir;   drive = 1'b1; end
         S_LOST:   begin motor_d = last_dir_q; drive = 1'b1; end
         default:  begin motor_d = DIR_OFF;    drive = 1'b0; end
      endcase
      en_d = drive ? {2{pwm_on}} : 2'b00;

      if (state_q == S_FOLLOW && !t_none && !t_all) last_dir_d = class_dir;

      if (red_f & ~red_prev_q) branch_d = ~branch_q;
      if (~red_f & red_prev_q) cone_d   = 1'b0;
      if (state_d == S_AVOID)  cone_d   = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         motor_q    <= DIR_OFF;
         en_q       <= 2'b00;
         last_dir_q <= DIR_FWD;
         branch_q   <= 1'b0;
         cone_q     <= 1'b0;
         red_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         motor_q    <= motor_d;
         en_q       <= en_d;
         last_dir_q <= last_dir_d;
         branch_q   <= branch_d;
         cone_q     <= cone_d;
         red_prev_q <= red_f;
      end
   end

   assign motor_in  = motor_q;
   assign motor_en  = en_q;
   assign state_o   = state_q;
   assign cone_seen = cone_q;

endmodule
